// File: rtl/ex_resolve_stage.sv
// Execute-resolve stage: a 2-entry skid FIFO that resolves zero/pos/taken flags
// at accept, retires in order, pulses flush and counts retired taken branches.
module ex_resolve_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_inst_id,
    input  logic [WIDTH-1:0] in_result,
    input  logic [WIDTH-1:0] in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_inst_id,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_target,
    output logic             out_zero,
    output logic             out_pos,
    output logic             out_taken,
    output logic             flush,
    output logic [15:0]      taken_count,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

    typedef struct packed {
        logic [3:0]       inst_id;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] target;
        logic             zero;
        logic             pos;
        logic             taken;
    } entry_t;

    occ_e             state_q, state_d;
    entry_t [1:0]     ent_q, ent_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             flush_q, flush_d;
    logic [15:0]      taken_count_q, taken_count_d;
    logic             accept, retire;
    entry_t           new_ent, head;

    // Handshake: a transfer happens only when valid and ready are both high at
    // a rising edge; in_ready/out_valid depend on registered occupancy only.
    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;
    assign head   = ent_q[rd_ptr_q];

    always_comb begin
        new_ent         = '0;
        new_ent.inst_id = in_inst_id;
        new_ent.result  = in_result;
        new_ent.target  = in_target;
        new_ent.zero    = (in_result == '0);
        new_ent.pos     = (in_result != '0) && !in_result[WIDTH-1];
        case (in_inst_id)
            4'b0011: new_ent.taken = new_ent.zero;
            4'b0101: new_ent.taken = !new_ent.zero;
            4'b0111: new_ent.taken = new_ent.pos;
            4'b1111: new_ent.taken = 1'b1;
            default: new_ent.taken = 1'b0;
        endcase
    end

    // Occupancy FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Occupancy FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !retire)      state_d = FULL;
                else if (retire && !accept) state_d = EMPTY;
            end
            FULL:    if (retire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy FSM: outputs
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        dbg_state = state_q;
    end

    always_comb begin
        ent_d         = ent_q;
        wr_ptr_d      = wr_ptr_q ^ accept;
        rd_ptr_d      = rd_ptr_q ^ retire;
        flush_d       = retire && head.taken;
        taken_count_d = taken_count_q;
        if (accept) ent_d[wr_ptr_q] = new_ent;
        if (retire && head.taken) taken_count_d = taken_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_q         <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            flush_q       <= 1'b0;
            taken_count_q <= '0;
        end else begin
            ent_q         <= ent_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            flush_q       <= flush_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign out_inst_id = head.inst_id;
    assign out_result  = head.result;
    assign out_target  = head.target;
    assign out_zero    = head.zero;
    assign out_pos     = head.pos;
    assign out_taken   = head.taken;
    assign flush       = flush_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_ex_resolve_stage.sv
// Bench for ex_resolve_stage: reference model plus expected-entry queue, one
// task per scenario, summary line at the end.
module tb_ex_resolve_stage;
  localparam int W  = 16;
  localparam int EW = 4 + 2 * W + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_inst_id;
  logic [W-1:0]  in_result;
  logic [W-1:0]  in_target;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_inst_id;
  logic [W-1:0]  out_result;
  logic [W-1:0]  out_target;
  logic          out_zero;
  logic          out_pos;
  logic          out_taken;
  logic          flush;
  logic [15:0]   taken_count;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_count;
  logic          exp_flush;
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [EW-1:0] dut_entry;

  assign dut_entry = {out_inst_id, out_result, out_target, out_zero, out_pos, out_taken};

  ex_resolve_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_result(in_result), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst_id(out_inst_id), .out_result(out_result), .out_target(out_target),
    .out_zero(out_zero), .out_pos(out_pos), .out_taken(out_taken),
    .flush(flush), .taken_count(taken_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model_entry(input logic [3:0] id, input logic [W-1:0] r,
                                                 input logic [W-1:0] t);
    logic z, p, tk;
    z = (r == 16'd0);
    p = (r != 16'd0) && (r < 16'h8000);
    if (id == 4'b0011)      tk = z;
    else if (id == 4'b0101) tk = !z;
    else if (id == 4'b0111) tk = p;
    else if (id == 4'b1111) tk = 1'b1;
    else                    tk = 1'b0;
    return {id, r, t, z, p, tk};
  endfunction

  // advance one clock and update the model from the inputs held across the edge
  task automatic tick(output bit acc);
    bit ret;
    logic [EW-1:0] head;
    acc  = in_valid && reset && (exp_q.size() < 2);
    ret  = reset && (exp_q.size() > 0) && out_ready;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    @(posedge clk);
    #1;
    if (!reset) begin
      exp_q.delete();
      exp_flush = 1'b0;
      exp_count = 16'd0;
    end else begin
      exp_flush = ret && head[0];
      if (ret) begin
        void'(exp_q.pop_front());
        if (head[0]) exp_count = exp_count + 16'd1;
      end
      if (acc) exp_q.push_back(model_entry(in_inst_id, in_result, in_target));
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [W-1:0] r, input logic [W-1:0] t);
    in_valid   = 1'b1;
    in_inst_id = id;
    in_result  = r;
    in_target  = t;
  endtask

  task automatic test_reset();
    bit a;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst_id = 4'd0; in_result = '0; in_target = '0;
    exp_count = 16'd0; exp_flush = 1'b0;
    tick(a); tick(a);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else pass_cnt++;
    total_cnt++; if (taken_count !== 16'd0) $display("FAIL reset_count got %h want 0", taken_count); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else pass_cnt++;
    total_cnt++; if (dut_entry !== '0) $display("FAIL reset_entry got %h want 0", dut_entry); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    bit a;
    out_ready = 1'b1;
    drive(4'b0000, 16'h0005, 16'h1234);
    tick(a);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_result !== 16'd5) $display("FAIL basic_result got %h want 5", out_result); else pass_cnt++;
    total_cnt++; if ({out_pos, out_zero, out_taken} !== 3'b100)
      $display("FAIL basic_flags got %b want 100", {out_pos, out_zero, out_taken}); else pass_cnt++;
    total_cnt++; if (dut_entry !== exp_q[0]) $display("FAIL basic_entry got %h want %h", dut_entry, exp_q[0]); else pass_cnt++;
    tick(a);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL basic_flush got %b want 0", flush); else pass_cnt++;
  endtask

  task automatic test_taken();
    bit a;
    out_ready = 1'b0;
    drive(4'b0011, 16'h0000, 16'h0040);
    tick(a);
    in_valid = 1'b0;
    total_cnt++; if (out_taken !== 1'b1) $display("FAIL taken_head got %b want 1", out_taken); else pass_cnt++;
    total_cnt++; if (dut_entry !== exp_q[0]) $display("FAIL taken_entry got %h want %h", dut_entry, exp_q[0]); else pass_cnt++;
    out_ready = 1'b1;
    tick(a);
    total_cnt++; if (flush !== 1'b1) $display("FAIL taken_flush got %b want 1", flush); else pass_cnt++;
    total_cnt++; if (taken_count !== 16'd1) $display("FAIL taken_count got %h want 1", taken_count); else pass_cnt++;
    tick(a);
    total_cnt++; if (flush !== 1'b0) $display("FAIL taken_flush_pulse got %b want 0", flush); else pass_cnt++;
  endtask

  task automatic test_negative();
    bit a;
    out_ready = 1'b0;
    drive(4'b0111, 16'h8000, 16'h0100);
    tick(a);
    in_valid = 1'b0;
    total_cnt++; if ({out_pos, out_zero, out_taken} !== 3'b000)
      $display("FAIL neg_flags got %b want 000", {out_pos, out_zero, out_taken}); else pass_cnt++;
    out_ready = 1'b1;
    tick(a);
    total_cnt++; if (taken_count !== exp_count) $display("FAIL neg_count got %h want %h", taken_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit a;
    out_ready = 1'b0;
    drive(4'b0101, 16'h0011, 16'h0A00);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", in_ready); else pass_cnt++;
    tick(a);
    drive(4'b0001, 16'h0022, 16'h0B00);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", in_ready); else pass_cnt++;
    tick(a);
    drive(4'b1111, 16'h0033, 16'h0C00);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd2) $display("FAIL b2b_full_state got %0d want 2", dbg_state); else pass_cnt++;
    tick(a);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_still_full got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_result !== 16'h0011) $display("FAIL b2b_hold got %h want 0011", out_result); else pass_cnt++;
    out_ready = 1'b1;
    tick(a);
    total_cnt++; if (out_result !== 16'h0022) $display("FAIL b2b_second got %h want 0022", out_result); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_again got %b want 1", in_ready); else pass_cnt++;
    tick(a);
    in_valid = 1'b0;
    total_cnt++; if (out_result !== 16'h0033) $display("FAIL b2b_third got %h want 0033", out_result); else pass_cnt++;
    total_cnt++; if (dut_entry !== exp_q[0]) $display("FAIL b2b_entry got %h want %h", dut_entry, exp_q[0]); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd1) $display("FAIL b2b_one got %0d want 1", dbg_state); else pass_cnt++;
    tick(a);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b1) $display("FAIL b2b_flush got %b want 1", flush); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit a;
    out_ready = 1'b0;
    drive(4'b1111, 16'h0001, 16'h0D00);
    tick(a);
    drive(4'b1111, 16'h0002, 16'h0E00);
    tick(a);
    total_cnt++; if (dbg_state !== 2'd2) $display("FAIL rmid_full got %0d want 2", dbg_state); else pass_cnt++;
    drive(4'b1111, 16'h0003, 16'h0F00);
    out_ready = 1'b1;
    reset = 1'b0;
    tick(a);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL rmid_flush got %b want 0", flush); else pass_cnt++;
    total_cnt++; if (taken_count !== 16'd0) $display("FAIL rmid_count got %h want 0", taken_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", in_ready); else pass_cnt++;
    reset = 1'b1;
    drive(4'b0000, 16'h0009, 16'h0000);
    tick(a);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rmid_first_accept got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (dut_entry !== exp_q[0]) $display("FAIL rmid_entry got %h want %h", dut_entry, exp_q[0]); else pass_cnt++;
    tick(a);
  endtask

  task automatic test_wrap();
    bit a;
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive(4'b1111, i[W-1:0], ~i[W-1:0]);
      tick(a);
    end
    total_cnt++; if (taken_count !== 16'hFFFF) $display("FAIL wrap_max got %h want ffff", taken_count); else pass_cnt++;
    in_valid = 1'b0;
    tick(a);
    total_cnt++; if (taken_count !== 16'h0000) $display("FAIL wrap_zero got %h want 0", taken_count); else pass_cnt++;
    total_cnt++; if (taken_count !== exp_count) $display("FAIL wrap_model got %h want %h", taken_count, exp_count); else pass_cnt++;
    total_cnt++; if (flush !== 1'b1) $display("FAIL wrap_flush got %b want 1", flush); else pass_cnt++;
  endtask

  task automatic test_random();
    bit a;
    logic [W-1:0] r;
    logic [3:0] id;
    a = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (a || !in_valid) begin
        case ($urandom_range(0, 5))
          0: id = 4'b0011;
          1: id = 4'b0101;
          2: id = 4'b0111;
          3: id = 4'b1111;
          4: id = 4'b0000;
          default: id = 4'($urandom_range(0, 15));
        endcase
        case ($urandom_range(0, 3))
          0: r = 16'h0000;
          1: r = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
          default: r = 16'($urandom_range(0, 16'hFFFF));
        endcase
        in_inst_id = id;
        in_result  = r;
        in_target  = 16'($urandom_range(0, 16'hFFFF));
        in_valid   = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      total_cnt++; if (in_ready !== (exp_q.size() < 2)) $display("FAIL rnd_ready got %b at %0d", in_ready, n); else pass_cnt++;
      total_cnt++; if (out_valid !== (exp_q.size() > 0)) $display("FAIL rnd_valid got %b at %0d", out_valid, n); else pass_cnt++;
      if (exp_q.size() > 0) begin
        total_cnt++; if (dut_entry !== exp_q[0]) $display("FAIL rnd_entry got %h want %h at %0d", dut_entry, exp_q[0], n); else pass_cnt++;
      end
      total_cnt++; if (flush !== exp_flush) $display("FAIL rnd_flush got %b want %b at %0d", flush, exp_flush, n); else pass_cnt++;
      total_cnt++; if (taken_count !== exp_count) $display("FAIL rnd_count got %h want %h at %0d", taken_count, exp_count, n); else pass_cnt++;
      tick(a);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_taken();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_resolve_stage.md
EX_RESOLVE_STAGE -- requirements
Module: ex_resolve_stage

Interface
REQ-001 Parameter WIDTH, default 16, sets the data width of the ALU result and the branch target.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  means the upstream ALU result is presented.
REQ-005 in_ready  output  1  means the stage can accept an entry this cycle.
REQ-006 in_inst_id  input  4  is the opcode of the instruction whose result is presented.
REQ-007 in_result  input  WIDTH  is the ALU output value.
REQ-008 in_target  input  WIDTH  is the branch target address carried alongside the result.
REQ-009 out_valid  output  1  means the head entry is presented downstream.
REQ-010 out_ready  input  1  means downstream accepts the head entry.
REQ-011 out_inst_id, out_result, out_target  output  4/WIDTH/WIDTH  are the head entry fields.
REQ-012 out_zero, out_pos, out_taken  output  1 each  are the resolved flags of the head entry.
REQ-013 flush  output  1  is a one-cycle pulse that marks the retirement of a taken branch.
REQ-014 taken_count  output  16  counts retired taken branches.

Function
REQ-015 Transfer occurs on in_valid&&in_ready (accept) and on out_valid&&out_ready (retire); no other event moves data.
REQ-016 Storage is a 2-entry FIFO (skid buffer), so in_ready = (occupancy < 2) and depends only on registered state.
REQ-017 Flags are computed at accept from in_result as two's complement: zero = (result==0); pos = (result!=0 && result[WIDTH-1]==0).
REQ-018 Upstream flag outputs are not used; flags are always recomputed from in_result.
REQ-019 taken is computed at accept: 4'b0011 -> zero; 4'b0101 -> !zero; 4'b0111 -> pos; 4'b1111 -> 1; every other opcode -> 0.
REQ-020 An accepted entry is visible on out_* on the next cycle, giving 1-cycle latency when the FIFO is empty.
REQ-021 Entries retire in acceptance order; out_* show the oldest entry and hold stable while out_valid && !out_ready.
REQ-022 out_valid = (occupancy > 0); when occupancy is 0, out_* data values are don't-care.
REQ-023 Occupancy states are EMPTY (0), ONE (1) and FULL (2).
REQ-024 State transitions: accept only -> +1; retire only -> -1; accept and retire together -> unchanged.
REQ-025 In FULL, in_ready = 0, and an in_valid in that cycle is not accepted; upstream holds the entry.
REQ-026 A simultaneous accept and retire in ONE leaves the new entry as head on the next cycle.
REQ-027 flush is registered: it is 1 in the cycle after an entry with taken=1 retires, and 0 otherwise.
REQ-028 taken_count increments by 1 on each retire with taken=1 and wraps from 16'hFFFF to 0.
REQ-029 flush does not clear the FIFO; upstream squashes younger instructions itself.

Reset
REQ-030 While reset==0 at a clock edge, the state becomes: occupancy EMPTY, out_valid=0, in_ready=1 after the edge, flush=0, taken_count=0, and stored entry fields = 0.
REQ-031 A reset asserted mid-operation discards all stored entries; an accept or retire in that cycle has no effect.
REQ-032 Following reset deassertion, the first accept is possible on the first edge at which reset==1.

Verification
REQ-033 Empty stage, out_ready=1, in_valid=1 with in_inst_id=4'b0000 and in_result=16'h0005 -> next cycle out_valid=1, out_result=5, out_pos=1, out_zero=0, out_taken=0.
REQ-034 Opcode 4'b0011 with result 0 is retired -> out_taken=1 at the head, flush=1 for exactly the following cycle, taken_count=1.
REQ-035 Opcode 4'b0111 with result 16'h8000 -> out_pos=0, out_zero=0, out_taken=0.
REQ-036 out_ready=0 and three back-to-back in_valid -> two entries accepted, then in_ready=0; after out_ready=1, the third entry is accepted and the order is preserved.
REQ-037 reset=0 is applied while FULL with a taken branch at the head -> next cycle out_valid=0, flush=0, taken_count=0, in_ready=1.
REQ-038 65536 taken 4'b1111 entries are retired -> taken_count wraps to 0.
